// File: rtl/pc_fetch_unit.sv
// Fetch stage: program counter, next-PC selection and the IF/ID pipeline
// register. A redirect is taken only together with kill, which also squashes
// the instruction fetched in that cycle.
// Optional feature macro: FETCH_PERF_CNT_EN builds a saturating count of
// killed fetches on kill_count; without it kill_count is tied to zero.
module pc_fetch_unit #(
  parameter int unsigned        PC_W      = 16,
  parameter int unsigned        INSTR_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               kill,
  input  logic [1:0]         pc_src,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    jr_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus1,
  output logic               ifid_valid,
  output logic [15:0]        kill_count
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [PC_W-1:0]    ifid_pc_plus1_q, ifid_pc_plus1_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    redirect_pc;

  // Sequential successor (wraps silently) and the redirect target chosen by pc_src.
  always_comb begin
    pc_plus1 = pc_q + PC_W'(1);
    case (pc_src)
      2'b01:   redirect_pc = jump_target;
      2'b10:   redirect_pc = jr_target;
      default: redirect_pc = pc_plus1;
    endcase
  end

  // Next state of PC and IF/ID: stall holds everything, kill redirects and
  // inserts a bubble, otherwise fetch sequentially.
  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus1_d = ifid_pc_plus1_q;
    ifid_valid_d    = ifid_valid_q;
    if (!stall) begin
      // The squashed fetch's PC is kept in IF/ID purely for debug visibility.
      ifid_pc_d       = pc_q;
      ifid_pc_plus1_d = pc_plus1;
      if (kill) begin
        pc_d         = redirect_pc;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end else begin
        pc_d         = pc_plus1;
        ifid_instr_d = imem_data;
        ifid_valid_d = 1'b1;
      end
    end
  end

  // PC and IF/ID registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= '0;
      ifid_pc_plus1_q <= '0;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus1_q <= ifid_pc_plus1_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] kill_count_q, kill_count_d;

  // Count killed fetches, sticking at all-ones rather than wrapping.
  always_comb begin
    kill_count_d = kill_count_q;
    if (kill && !stall && (kill_count_q != 16'hFFFF)) begin
      kill_count_d = kill_count_q + 16'd1;
    end
  end

  // Kill counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      kill_count_q <= '0;
    end else begin
      kill_count_q <= kill_count_d;
    end
  end

  assign kill_count = kill_count_q;
`else
  assign kill_count = 16'h0000;
`endif

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus1 = ifid_pc_plus1_q;
  assign ifid_valid    = ifid_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a driver applies one stimulus per cycle
// and pushes the reference model's expected post-edge state; a monitor pops
// and compares on the following falling edge.
module tb_pc_fetch_unit;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, stall, kill;
  logic [1:0]  pc_src;
  logic [15:0] jump_target, jr_target;
  logic [15:0] imem_addr, imem_data, pc, ifid_instr, ifid_pc, ifid_pc_plus1;
  logic        ifid_valid;
  logic [15:0] kill_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic [15:0] ipc1;
    logic        valid;
    logic [15:0] kc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [15:0] m_pc, m_instr, m_ipc, m_ipc1;
  logic        m_valid;
  int          m_kc;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  assign imem_data = mem_word(imem_addr);

  pc_fetch_unit #(
    .PC_W(16), .INSTR_W(16), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .kill(kill), .pc_src(pc_src),
    .jump_target(jump_target), .jr_target(jr_target), .imem_addr(imem_addr),
    .imem_data(imem_data), .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid), .kill_count(kill_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc", ifid_pc, e.ipc);
        chk("ifid_pc_plus1", ifid_pc_plus1, e.ipc1);
        chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, e.valid});
        chk("kill_count", kill_count, e.kc);
      end
    end
  end

  // One clock of stimulus; the model evolves from the spec's edge rules.
  task automatic step(input bit r, input bit s, input bit k, input logic [1:0] src,
                      input logic [15:0] jt, input logic [15:0] jrt);
    logic [15:0] tgt;
    exp_t e;
    reset = r; stall = s; kill = k; pc_src = src; jump_target = jt; jr_target = jrt;
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_ipc = 16'h0; m_ipc1 = 16'h0;
      m_valid = 1'b0; m_kc = 0;
    end else if (s) begin
      // everything holds
    end else if (k) begin
      if (src == 2'b01)      tgt = jt;
      else if (src == 2'b10) tgt = jrt;
      else                   tgt = m_pc + 16'd1;
      m_instr = NOP_INSTR; m_ipc = m_pc; m_ipc1 = m_pc + 16'd1; m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      if (m_kc < 65535) m_kc++;
`endif
      m_pc = tgt;
    end else begin
      m_instr = mem_word(m_pc); m_ipc = m_pc; m_ipc1 = m_pc + 16'd1; m_valid = 1'b1;
      m_pc = m_pc + 16'd1;
    end
    e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ipc1 = m_ipc1;
    e.valid = m_valid; e.kc = 16'(m_kc);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    reset = 1'b1; stall = 1'b0; kill = 1'b0; pc_src = 2'b00;
    jump_target = '0; jr_target = '0;
    m_pc = '0; m_instr = '0; m_ipc = '0; m_ipc1 = '0; m_valid = 1'b0; m_kc = 0;
    @(negedge clk);

    // Reset then sequential fetch
    step(1, 0, 0, 2'b00, 16'h0, 16'h0);
    step(1, 0, 0, 2'b00, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 2'b00, 16'h0, 16'h0);
    guard = 0;
    while (m_pc != 16'h0005 && guard < 20) begin
      step(0, 0, 0, 2'b00, 16'h0, 16'h0);
      guard++;
    end
    // Jump with bubble, then target instruction valid
    step(0, 0, 1, 2'b01, 16'h0040, 16'h0);
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);
    // JR and reserved pc_src without kill
    step(0, 0, 1, 2'b10, 16'h0999, 16'h1234);
    step(0, 0, 0, 2'b11, 16'h0777, 16'h0555);
    step(0, 0, 0, 2'b01, 16'h0777, 16'h0555);
    // Stall overrides kill for 3 cycles, then the redirect is taken
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b01, 16'h0080, 16'h0);
    step(0, 0, 1, 2'b01, 16'h0080, 16'h0);
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);
    // Consecutive kills
    step(0, 0, 1, 2'b01, 16'h0200, 16'h0);
    step(0, 0, 1, 2'b10, 16'h0, 16'h0300);
    step(0, 0, 1, 2'b11, 16'h0, 16'h0);
    // Wrap from all-ones
    step(0, 0, 1, 2'b01, 16'hFFFF, 16'h0);
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);
    // Reset beats kill and stall
    step(1, 0, 1, 2'b01, 16'h0444, 16'h0);
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);
    step(1, 1, 1, 2'b10, 16'h0, 16'h0666);
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, k;
      logic [15:0] jt, jrt;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 20);
      k   = ($urandom_range(0, 99) < 25);
      jt  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      jrt = 16'($urandom);
      step(r, s, k, 2'($urandom_range(0, 3)), jt, jrt);
    end

`ifdef FETCH_PERF_CNT_EN
    // Counter saturation
    step(1, 0, 0, 2'b00, 16'h0, 16'h0);
    for (int i = 0; i < 65540; i++) step(0, 0, 1, 2'b01, 16'(i), 16'h0);
    step(0, 1, 1, 2'b01, 16'h0010, 16'h0);
    step(0, 0, 0, 2'b00, 16'h0, 16'h0);
`endif

    guard = 0;
    while (exp_q.size() > 0 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage consumer of the PC control unit's `pcSrc`/`Kill` outputs. It holds the program counter, selects the next PC (PC+1, PC-relative jump/call target, or JR register target), and drives the instruction-memory address. It also owns the IF/ID pipeline register and squashes the wrong-path fetched instruction when `kill` is asserted. It sits between instruction memory and the decode stage; redirect and hazard controls come back from decode.

## Interface
Parameters:
- PC_W, 16, program-counter width (word-addressed)
- INSTR_W, 16, instruction width
- RESET_PC, 0, PC value after reset
- NOP_INSTR, 0, encoding loaded into the IF/ID register on kill or reset

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- stall  input  1  hold PC and IF/ID (load-use hazard)
- kill  input  1  squash the instruction currently being fetched
- pc_src  input  2  00 PC+1, 01 jump/call target, 10 JR target, 11 reserved (treated as 00)
- jump_target  input  PC_W  PC+offset, computed in decode
- jr_target  input  PC_W  register value for JR
- imem_addr  output  PC_W  instruction-memory address; equals pc
- imem_data  input  INSTR_W  instruction, combinational from imem_addr in the same cycle
- pc  output  PC_W  current PC register
- ifid_instr  output  INSTR_W  IF/ID instruction
- ifid_pc  output  PC_W  PC of ifid_instr
- ifid_pc_plus1  output  PC_W  ifid_pc+1, used as the CALL return address
- ifid_valid  output  1  IF/ID holds a real instruction
- kill_count  output  16  killed-fetch counter (see Configuration)

## Operation
- Next-PC selection: 00 or 11 → pc+1; 01 → jump_target; 10 → jr_target.
- PC arithmetic is modulo 2^PC_W. pc+1 at all-ones wraps to 0 with no flag.
- Priority at each rising edge: reset > stall > kill > normal.
- reset: pc←RESET_PC, ifid_instr←NOP_INSTR, ifid_pc←0, ifid_pc_plus1←0, ifid_valid←0, kill_count←0.
- stall=1: pc and every IF/ID field hold. kill and pc_src are ignored, because the decode instruction that generated them is itself held and re-presents them when stall drops.
- kill=1, stall=0:
  - pc←selected target.
  - ifid_instr←NOP_INSTR, ifid_valid←0; ifid_pc and ifid_pc_plus1 load the squashed fetch's PC and PC+1 (debug only).
- normal (kill=0, stall=0):
  - pc←pc+1 regardless of pc_src. A redirect is only honoured with kill, since the PC control unit always pairs them.
  - IF/ID loads {imem_data, pc, pc+1}; ifid_valid←1.
- No internal FSM beyond the PC and IF/ID registers. kill_count is the only extra state.

## Timing
- imem_addr = pc, combinational from the register. No address-to-instruction latency inside this block.
- Redirect latency, with kill and pc_src=01 sampled at edge N:
  - pc=target after edge N.
  - Target instruction in IF/ID after edge N+1 with ifid_valid=1.
  - Exactly one bubble (ifid_valid=0) between edges N and N+1.
- Stall: an edge with stall=1 changes no output except through reset.
- Reset is released when reset is sampled 0:
  - The first fetch of RESET_PC happens in that cycle.
  - ifid_valid first rises at the following edge.
- Reset asserted mid-redirect or mid-stall overrides both; no pending redirect survives reset.
- kill held for consecutive cycles: each cycle redirects and squashes independently.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - kill_count increments on every edge with kill=1, stall=0, reset=0.
  - It saturates at 16'hFFFF and clears on reset.
- FETCH_PERF_CNT_EN undefined:
  - No counter flops are built; kill_count is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset/sequential fetch: RESET_PC=0, reset for 2 cycles, then release with no stall/kill → pc steps 0,1,2,3; ifid_pc 0,1,2 with ifid_valid=1 from the 2nd post-reset edge; ifid_pc_plus1=ifid_pc+1.
- Jump: at pc=5, kill=1, pc_src=01, jump_target=0x40 → pc=0x40 next edge, one bubble (ifid_valid=0, ifid_instr=NOP_INSTR), then ifid_pc=0x40 valid; kill_count=1 with macro, 0 without.
- JR and reserved code: kill=1, pc_src=10, jr_target=0x1234 → pc=0x1234. Separately, kill=0, pc_src=11 → pc=pc+1.
- Stall priority: stall=1 for 3 cycles with kill=1, pc_src=01, target=0x80 → pc and IF/ID unchanged, kill_count unchanged; on stall drop with kill still 1 → pc=0x80.
- Wrap and reset mid-operation: pc=0xFFFF, normal → pc=0x0000. Reset asserted in the same cycle as kill=1 → pc=RESET_PC, ifid_valid=0, kill_count=0.
- Counter saturation (macro on): force 65,536+ kill cycles → kill_count holds 16'hFFFF.
